mul_div_unit: RTL and testbench

Iterative multiply/divide unit for the LC-3 datapath family, parametrised in operand width. It generalises the single-purpose multiplier behind the `MUL_EN`/`MUL_R`/`GateMUL` signals into a four-mode unit (signed/unsigned multiply, signed/unsigned divide) with a start/ready handshake and divide-by-zero reporting. It sits beside the ALU; the control FSM pulses `Start`, waits for `Ready`, then gates `Result_Lo`/`Result_Hi` onto the bus.

---
 rtl/mul_div_pkg.sv | 28 ++
 rtl/mul_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared types and op decode helpers for the iterative multiply/divide unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mul_div_pkg;

  typedef enum logic [1:0] {
    MULU = 2'b00,
    MULS = 2'b01,
    DIVU = 2'b10,
    DIVS = 2'b11
  } mul_div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mul_div_state_t;

  function automatic logic is_signed(input mul_div_op_t op);
    return op[0];
  endfunction

  function automatic logic is_div(input mul_div_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply and restoring divide on operand magnitudes.
// Latency: WIDTH+2 cycles from accepted Start to Ready; divide-by-zero answers in 1.
// Backpressure: Start is ignored while Busy; results hold in DONE until the next Start.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Ready,
  output logic [WIDTH-1:0] Result_Lo,
  output logic [WIDTH-1:0] Result_Hi,
  output logic             Div_By_Zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Conditional two's-complement negation; the carry-in lets a 2*WIDTH
  // product be negated one half at a time with the same logic.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic en,
                                                input logic cin);
    return en ? (~x + {{(WIDTH-1){1'b0}}, cin}) : x;
  endfunction

  mul_div_state_t   state_q, state_d;
  mul_div_op_t      op_q, op_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dbz_q, dbz_d;

  mul_div_op_t      op_in;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] fix_lo, fix_hi;
  logic             hi_cin;

  assign op_in = mul_div_op_t'(Op);
  assign a_neg = is_signed(op_in) & A[WIDTH-1];
  assign b_neg = is_signed(op_in) & B[WIDTH-1];
  assign a_mag = cond_neg(A, a_neg, 1'b1);
  assign b_mag = cond_neg(B, b_neg, 1'b1);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits becoming quotient bits}.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
  assign div_step = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};

  // Quotient and remainder negate independently; a product's high half
  // takes the carry out of the low half's negation.
  assign hi_cin = is_div(op_q) ? 1'b1 : (acc_q[WIDTH-1:0] == '0);
  assign fix_lo = cond_neg(acc_q[WIDTH-1:0], neg_lo_q, 1'b1);
  assign fix_hi = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_hi_q, hi_cin);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          op_d     = op_in;
          ready_d  = 1'b0;
          dbz_d    = 1'b0;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = is_div(op_in) ? a_neg : (a_neg ^ b_neg);
          if (is_div(op_in)) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          if (is_div(op_in) && (B == '0)) begin
            state_d = DONE;
            ready_d = 1'b1;
            dbz_d   = 1'b1;
            lo_d    = '1;
            hi_d    = A;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      CALC: begin
        acc_d = is_div(op_q) ? div_step : mul_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = fix_lo;
        hi_d    = fix_hi;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      op_q     <= MULU;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Busy        = busy_q;
  assign Ready       = ready_q;
  assign Result_Lo   = lo_q;
  assign Result_Hi   = hi_q;
  assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit (WIDTH=16): vector table, scoreboard queue, timing corners.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [1:0]  Op;
  logic [15:0] A, B;
  logic        Busy, Ready, Div_By_Zero;
  logic [15:0] Result_Lo, Result_Hi;

  mul_div_unit #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Ready(Ready), .Result_Lo(Result_Lo), .Result_Hi(Result_Hi),
    .Div_By_Zero(Div_By_Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
  } exp_t;

  exp_t sq[$];
  int   n_pass   = 0;
  int   n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference arithmetic done with wide native integers, not shift/add.
  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t   r;
    longint sa, sbv, p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    r.dbz = 1'b0;
    case (op)
      2'd0: begin p = longint'(a) * longint'(b); r.lo = p[15:0]; r.hi = p[31:16]; end
      2'd1: begin p = sa * sbv; r.lo = p[15:0]; r.hi = p[31:16]; end
      2'd2: begin
        if (b == 16'h0) begin r.lo = 16'hFFFF; r.hi = a; r.dbz = 1'b1; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
      default: begin
        if (b == 16'h0) begin r.lo = 16'hFFFF; r.hi = a; r.dbz = 1'b1; end
        else begin p = sa / sbv; r.lo = p[15:0]; p = sa % sbv; r.hi = p[15:0]; end
      end
    endcase
    return r;
  endfunction

  // Issue one op, then watch Busy/Ready per cycle until the result appears.
  // glitch_at > 0 pulses a competing Start so that it is sampled at edge k+glitch_at.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input exp_t e_in, input int glitch_at, input string tag);
    exp_t e;
    int   j, busy_cnt, lat;
    bit   both, got;
    lat = e_in.dbz ? 1 : 18;
    @(posedge Clk); #1;
    Op = op; A = a; B = b; Start = 1'b1;
    sq.push_back(e_in);
    @(posedge Clk); #1;
    Start = 1'b0; Op = 2'($urandom); A = 16'($urandom); B = 16'($urandom);
    busy_cnt = 0; both = 0; got = 0;
    for (j = 1; j <= 40; j++) begin
      @(negedge Clk);
      if (j == 1) check({tag, " dbz@k+1"}, Div_By_Zero, e_in.dbz);
      if (Busy && Ready) both = 1;
      if (Busy) busy_cnt++;
      if (glitch_at > 0 && j == glitch_at) begin
        Start = 1'b1; Op = 2'b10; A = 16'h0009; B = 16'h0000;
      end
      if (glitch_at > 0 && j == glitch_at + 1) Start = 1'b0;
      if (Ready) begin got = 1; break; end
    end
    Start = 1'b0;
    check({tag, " ready latency"}, j, lat);
    check({tag, " busy cycles"}, busy_cnt, lat - 1);
    check({tag, " busy&ready overlap"}, both, 0);
    e = sq.pop_front();
    check({tag, " lo"}, Result_Lo, e.lo);
    check({tag, " hi"}, Result_Hi, e.hi);
    check({tag, " dbz"}, Div_By_Zero, e.dbz);
    if (!got) $display("FAIL %s timeout: got no Ready, required Ready within 40 cycles", tag);
  endtask

  vec_t vecs[17];

  initial begin
    exp_t e;
    logic [1:0]  rop;
    logic [15:0] ra, rb;

    vecs[0]  = '{MULU, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0};
    vecs[1]  = '{MULS, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 1'b0};
    vecs[2]  = '{MULU, 16'hFFFD, 16'h0007, 16'hFFEB, 16'h0006, 1'b0};
    vecs[3]  = '{DIVS, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
    vecs[4]  = '{DIVU, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
    vecs[5]  = '{DIVU, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    vecs[6]  = '{MULS, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0};
    vecs[7]  = '{DIVS, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
    vecs[8]  = '{MULU, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0};
    vecs[9]  = '{MULS, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0};
    vecs[10] = '{MULS, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    vecs[11] = '{DIVS, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0};
    vecs[12] = '{DIVS, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0};
    vecs[13] = '{DIVS, 16'h8001, 16'h0000, 16'hFFFF, 16'h8001, 1'b1};
    vecs[14] = '{DIVU, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
    vecs[15] = '{DIVU, 16'h0003, 16'h0007, 16'h0000, 16'h0003, 1'b0};
    vecs[16] = '{MULS, 16'h7FFF, 16'h8000, 16'h8000, 16'hC000, 1'b0};

    Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; A = 16'h0; B = 16'h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset busy", Busy, 0);
    check("reset ready", Ready, 0);
    check("reset lo", Result_Lo, 0);
    check("reset hi", Result_Hi, 0);
    check("reset dbz", Div_By_Zero, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      e.lo = vecs[i].lo; e.hi = vecs[i].hi; e.dbz = vecs[i].dbz;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, 0, $sformatf("vec%0d", i));
    end

    // Competing Start at k+5 must be ignored; first result stands and nothing restarts.
    e.lo = 16'h000F; e.hi = 16'h0000; e.dbz = 1'b0;
    run_op(MULU, 16'h0003, 16'h0005, e, 5, "ignored_start");
    repeat (3) @(negedge Clk);
    check("ignored_start ready held", Ready, 1);
    check("ignored_start no restart", Busy, 0);
    check("ignored_start lo held", Result_Lo, 16'h000F);
    check("ignored_start dbz held", Div_By_Zero, 0);

    // Reset at k+9 aborts the op; no partial result may surface afterwards.
    @(posedge Clk); #1;
    Op = MULU; A = 16'h00FF; B = 16'h0101; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    check("abort busy before reset", Busy, 1);
    #1 Reset_n = 1'b0;
    #1;
    check("abort busy", Busy, 0);
    check("abort ready", Ready, 0);
    check("abort lo", Result_Lo, 0);
    check("abort hi", Result_Hi, 0);
    check("abort dbz", Div_By_Zero, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    check("abort stays idle ready", Ready, 0);
    check("abort stays idle lo", Result_Lo, 0);
    e.lo = 16'hFFFD; e.hi = 16'hFFFF; e.dbz = 1'b0;
    run_op(DIVS, 16'hFFF9, 16'h0002, e, 0, "after_reset");

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom);
      ra  = 16'($urandom);
      rb  = (i == 3) ? 16'h0 : 16'($urandom);
      run_op(rop, ra, rb, model(rop, ra, rb), 0, $sformatf("rnd%0d op%0d %h/%h", i, rop, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1ms, required completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
